lap_mem_arbiter: RTL

//  Shares the single-port lap RAM between two requesters: the chronometer control (lap writes)
//  and the display/recall path (lap reads). Two-way round-robin on simultaneous requests,
//  one transaction in flight at a time, registered RAM-side outputs, one-cycle ack/done pulses.

---
 rtl/lap_mem_arbiter_pkg.sv | 26 ++
 rtl/lap_mem_arbiter_rr_arb2.sv | 32 +++
 rtl/lap_mem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lap_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lap_mem_arbiter_pkg
//  Description : Shared definitions for the lap RAM arbiter. This file holds
//                the FSM state encodings, the requester IDs and the width of
//                the read wait counter.
//  Revision    : 1.0  initial release
// ============================================================================
package lap_mem_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Requester IDs. These double as bit positions in the two-bit request vector.
    typedef logic gnt_id_t;
    localparam gnt_id_t c_GNT_WR = 1'b0;
    localparam gnt_id_t c_GNT_RD = 1'b1;

    // Width of the read wait counter. It covers RD_LATENCY values up to 15.
    localparam int c_WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/lap_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick.
//                A single request wins outright.
//                When both requests are present, the side opposite 'last' wins.
//  Ports       : req[1:0]  requests, indexed by requester ID (0=write, 1=read)
//                last      ID of the side that won the previous tie
//                gnt_id    ID of the chosen requester
//                gnt_valid at least one request is present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_valid
);
    import lap_mem_arbiter_pkg::*;

    always_comb begin
        gnt_valid = |req;
        gnt_id    = c_GNT_WR;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[c_GNT_RD]) begin
            gnt_id = c_GNT_RD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lap_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lap_mem_arbiter
//  Description : Shares the single-port lap RAM between the chronometer
//                control (writes) and the display/recall path (reads).
//                Only one transaction is in flight at a time.
//                Simultaneous requests are resolved round-robin.
//                RAM-side outputs are registered.
//                Completion is signalled by one-cycle ack/done pulses.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                wr_req/wr_addr_i/wr_data_i  write request, held until wr_ack
//                wr_ack                   write committed (1-cycle pulse)
//                rd_req/rd_addr_i         read request, held until rd_done
//                rd_data_o, rd_done       captured read data, valid pulse
//                busy                     FSM not in IDLE
//                mem_cs/we/addr/wdata     registered RAM controls
//                mem_rdata                RAM read data
//  Revision    : 1.0  initial release
// ============================================================================
module lap_mem_arbiter #(
    parameter int ADDR_SIZE  = 10,
    parameter int DATA_SIZE  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    output logic                 wr_ack,
    input  logic                 rd_req,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    output logic [DATA_SIZE-1:0] rd_data_o,
    output logic                 rd_done,
    output logic                 busy,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);
    import lap_mem_arbiter_pkg::*;

    // The counter is loaded with RD_LATENCY on entry to READ, so READ lasts
    // RD_LATENCY+1 cycles. The RAM captures the address on the first READ
    // edge, and its data is therefore valid on the last one.
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(RD_LATENCY);

    logic [1:0]          r_state;
    logic                r_last;
    logic [c_WAIT_W-1:0] r_wait;
    logic [1:0]          w_req;
    logic                w_gnt_id;
    logic                w_gnt_valid;

    assign w_req = {rd_req, wr_req};
    assign busy  = (r_state != c_ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .req       (w_req),
        .last      (r_last),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_last    <= c_GNT_RD;
            r_wait    <= '0;
            wr_ack    <= 1'b0;
            rd_done   <= 1'b0;
            rd_data_o <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            wr_ack  <= 1'b0;
            rd_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_gnt_valid) begin
                        // Round-robin history advances on ties only. A lone requester
                        // does not consume the other side's turn.
                        if (w_req == 2'b11) begin
                            r_last <= w_gnt_id;
                        end
                        mem_cs <= 1'b1;
                        if (w_gnt_id == c_GNT_WR) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr_i;
                            mem_wdata <= wr_data_i;
                            r_state   <= c_ST_WRITE;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= rd_addr_i;
                            r_wait   <= c_WAIT_LOAD;
                            r_state  <= c_ST_READ;
                        end
                    end
                end
                c_ST_WRITE: begin
                    mem_cs  <= 1'b0;
                    mem_we  <= 1'b0;
                    wr_ack  <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                c_ST_READ: begin
                    if (r_wait == '0) begin
                        mem_cs    <= 1'b0;
                        rd_data_o <= mem_rdata;
                        rd_done   <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                c_ST_DONE: begin
                    // Requests are still high here and must not be resampled.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
